// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, keymap lookup and FSM state types shared by the keypad entry blocks.
package keypad_pkg;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    // Nibble {col, row} of this constant is the code for that switch; C1R1 is the LS nibble.
    localparam logic [63:0] KEYMAP = 64'hDCBA_E963_F852_0741;
    typedef enum logic [1:0] {DRIVE, SETTLE, HOLD} scan_st_t;
    typedef enum logic {IDLE, PRESSED} deb_st_t;
    function automatic logic [3:0] keymap(input logic [1:0] col_idx, input logic [1:0] row_idx);
        return KEYMAP[{col_idx, row_idx, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: valid/ready channel carrying a completed code to the compare logic.
interface keypad_entry_ctrl_if #(parameter int DIGITS = 4);
    logic [4*DIGITS-1:0] code_out;
    logic code_valid;
    logic code_ready;
    modport master(output code_out, code_valid, input code_ready);
    modport slave(input code_out, code_valid, output code_ready);
endinterface

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: column scan, once-per-slot row sampling and frame debounce into one-shot key events.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 100000,
    parameter int SETTLE_TICKS = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_strobe
);
    localparam int TW = $clog2(SCAN_TICKS + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] LAST = TW'(SCAN_TICKS - 1);
    localparam logic [TW-1:0] SET = TW'(SETTLE_TICKS);
    localparam logic [DW-1:0] DB = DW'(DEBOUNCE_SCANS);
    scan_st_t st, st_nxt;
    deb_st_t db, db_nxt;
    logic [TW-1:0] tick;
    logic [1:0] cidx, ridx;
    logic [3:0] col_nxt, acc_code, cur_code, cand;
    logic [DW-1:0] db_cnt, run, cnt_nxt;
    logic last, sample, frame_done, acc_hit, cur_hit, same, accept;
    assign last = tick == LAST;
    // Reset parks the scan on the last tick of C4 so the next edge starts a fresh frame at C1.
    always_ff @(posedge clk)
        if (rst) begin
            st <= HOLD;
            tick <= LAST;
            cidx <= 2'd3;
            col <= 4'hF;
        end else begin
            st <= st_nxt;
            tick <= last ? '0 : tick + TW'(1);
            cidx <= cidx + {1'b0, last};
            col <= col_nxt;
        end
    always_comb
        st_nxt = st == DRIVE ? SETTLE : (st == SETTLE && tick != SET) ? SETTLE : last ? DRIVE : HOLD;
    always_comb begin
        sample = st == SETTLE && tick == SET;
        frame_done = sample && cidx == 2'd3;
        col_nxt = last ? ~(4'b1000 >> (cidx + 2'd1)) : col;
    end
    assign ridx = !row[3] ? 2'd0 : !row[2] ? 2'd1 : !row[1] ? 2'd2 : 2'd3;
    assign cur_hit = acc_hit || (sample && !(&row));
    assign cur_code = acc_hit ? acc_code : keymap(cidx, ridx);
    assign same = cur_hit && cur_code == cand && db_cnt != '0;
    always_ff @(posedge clk)
        if (rst) begin
            acc_hit <= 1'b0;
            acc_code <= '0;
            db <= IDLE;
            db_cnt <= '0;
            cand <= '0;
            key_code <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= accept;
            if (accept) key_code <= cur_code;
            if (sample) begin
                acc_hit <= cur_hit && !frame_done;
                acc_code <= cur_code;
            end
            if (frame_done) begin
                db <= db_nxt;
                db_cnt <= cnt_nxt;
                if (cur_hit) cand <= cur_code;
            end
        end
    // In PRESSED only NONE frames count, so other keys neither release nor repeat.
    always_comb begin
        run = db == IDLE ? (same ? db_cnt + DW'(1) : DW'(cur_hit)) : (cur_hit ? '0 : db_cnt + DW'(1));
        db_nxt = run == DB ? (db == IDLE ? PRESSED : IDLE) : db;
        cnt_nxt = run == DB ? '0 : run;
    end
    always_comb
        accept = frame_done && db == IDLE && run == DB;
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad scan plus DIGITS-nibble code entry buffer with valid/ready hand-off.
// Defining KEYPAD_AUTO_SUBMIT_EN submits on the final digit instead of on the F key.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 100000,
    parameter int SETTLE_TICKS = 8,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   row,
    output logic [3:0]                   col,
    output logic [3:0]                   key_code,
    output logic                         key_strobe,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
    keypad_entry_ctrl_if.master          bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
`ifdef KEYPAD_AUTO_SUBMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic [4*DIGITS-1:0] code_nxt;
    logic [CW-1:0] cnt_nxt;
    logic valid_nxt, take, full, empty, is_digit;
    keypad_scan_debounce #(
        .SCAN_TICKS(SCAN_TICKS),
        .SETTLE_TICKS(SETTLE_TICKS),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scan (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_strobe(key_strobe)
    );
    assign take = key_strobe && !bus.code_valid;
    assign full = entry_cnt == FULL;
    assign empty = entry_cnt == '0;
    assign is_digit = key_code < KEY_CLEAR;
    // A pending handshake wins; keys arriving while the code is held are dropped.
    always_comb begin
        code_nxt = bus.code_out;
        cnt_nxt = entry_cnt;
        valid_nxt = bus.code_valid;
        if (bus.code_valid && bus.code_ready) begin
            code_nxt = '0;
            cnt_nxt = '0;
            valid_nxt = 1'b0;
        end else if (take && is_digit && !full) begin
            code_nxt = {bus.code_out[4*DIGITS-5:0], key_code};
            cnt_nxt = entry_cnt + CW'(1);
            valid_nxt = AUTO && cnt_nxt == FULL;
        end else if (take && key_code == KEY_CLEAR && !empty) begin
            code_nxt = {4'h0, bus.code_out[4*DIGITS-1:4]};
            cnt_nxt = entry_cnt - CW'(1);
        end else if (!AUTO && take && key_code == KEY_ENTER && full) begin
            valid_nxt = 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            bus.code_out <= '0;
            bus.code_valid <= 1'b0;
            entry_cnt <= '0;
        end else begin
            bus.code_out <= code_nxt;
            bus.code_valid <= valid_nxt;
            entry_cnt <= cnt_nxt;
        end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed keypad presses with a strobe-driven scoreboard of expected buffer states.
module tb_keypad_entry_ctrl;
    localparam int DIGITS = 4;
`ifdef KEYPAD_AUTO_SUBMIT_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif
    typedef struct {
        logic [3:0] key;
        logic [2:0] cnt;
        logic [15:0] code;
        logic valid;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] row, col, key_code;
    logic key_strobe;
    logic [2:0] entry_cnt;
    logic [15:0] down = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    exp_t e;
    keypad_entry_ctrl_if #(.DIGITS(DIGITS)) bus();
    keypad_entry_ctrl #(
        .SCAN_TICKS(16),
        .SETTLE_TICKS(4),
        .DEBOUNCE_SCANS(2),
        .DIGITS(DIGITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_strobe(key_strobe),
        .entry_cnt(entry_cnt),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    // Keypad model: a held switch pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col[3-c])
                for (int r = 0; r < 4; r++)
                    if (down[c*4+r]) row[3-r] = 1'b0;
    end
    function automatic int pos(input logic [3:0] k);
        case (k)
            4'h1: return 0;  4'h4: return 1;  4'h7: return 2;  4'h0: return 3;
            4'h2: return 4;  4'h5: return 5;  4'h8: return 6;  4'hF: return 7;
            4'h3: return 8;  4'h6: return 9;  4'h9: return 10; 4'hE: return 11;
            4'hA: return 12; 4'hB: return 13; 4'hC: return 14; default: return 15;
        endcase
    endfunction
    function automatic logic [3:0] pat(input int s);
        logic [3:0] b;
        b = 4'b1000;
        return ~(b >> s);
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic hold(input logic [15:0] m, input int on);
        @(negedge clk);
        down = m;
        repeat (on) @(negedge clk);
        down = '0;
        repeat (192) @(negedge clk);
    endtask
    task automatic key(input logic [3:0] k, input logic [2:0] cnt, input logic [15:0] code, input logic v);
        exp_q.push_back('{k, cnt, code, v});
        hold(16'(1) << pos(k), 192);
    endtask
    // Monitor: every strobe consumes one expectation; the buffer is checked on the following cycle.
    always @(negedge clk) begin
        if (!rst && key_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got key %0h expected no strobe", key_code);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_key", key_code, e.key);
                chk("strobe_phase", (cyc - 1) % 64, 53);
                @(negedge clk);
                chk("strobe_width", key_strobe, 0);
                chk("entry_cnt", entry_cnt, e.cnt);
                chk("code_out", bus.code_out, e.code);
                chk("code_valid", bus.code_valid, e.valid);
            end
        end
    end
    initial begin
        bus.code_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'hF);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_key", key_code, 0);
        chk("rst_cnt", entry_cnt, 0);
        chk("rst_code", bus.code_out, 0);
        chk("rst_valid", bus.code_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 5; s++) begin
            chk("scan_col_first", col, pat(s % 4));
            repeat (15) @(posedge clk);
            #1;
            chk("scan_col_last", col, pat(s % 4));
            @(posedge clk);
            #1;
        end
        key(4'h5, 1, 16'h0005, 0);
        key(4'hF, 1, 16'h0005, 0);
        key(4'hE, 0, 16'h0000, 0);
        key(4'hE, 0, 16'h0000, 0);
        key(4'h1, 1, 16'h0001, 0);
        key(4'h2, 2, 16'h0012, 0);
        key(4'h3, 3, 16'h0123, 0);
        key(4'hA, 4, 16'h123A, AUTO);
        key(4'hF, 4, 16'h123A, 1);
        key(4'h7, 4, 16'h123A, 1);
        chk("held_code", bus.code_out, 16'h123A);
        bus.code_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_valid", bus.code_valid, 0);
        chk("hs_cnt", entry_cnt, 0);
        chk("hs_code", bus.code_out, 0);
        @(negedge clk);
        bus.code_ready = 1'b0;
        hold(16'(1) << pos(4'h6), 64);
        chk("glitch_cnt", entry_cnt, 0);
        exp_q.push_back('{4'h1, 3'd1, 16'h0001, 1'b0});
        hold((16'(1) << pos(4'h1)) | (16'(1) << pos(4'hD)), 192);
        key(4'hE, 0, 16'h0000, 0);
        key(4'h7, 1, 16'h0007, 0);
        key(4'h8, 2, 16'h0078, 0);
        key(4'hE, 1, 16'h0007, 0);
        bus.code_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready_cnt", entry_cnt, 1);
        chk("idle_ready_code", bus.code_out, 16'h0007);
        bus.code_ready = 1'b0;
        key(4'h1, 2, 16'h0071, 0);
        key(4'h2, 3, 16'h0712, 0);
        key(4'h3, 4, 16'h7123, AUTO);
        key(4'h4, 4, 16'h7123, AUTO);
        key(4'hF, 4, 16'h7123, 1);
        chk("pre_rst_queue", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_col", col, 4'hF);
        chk("mid_rst_key", key_code, 0);
        chk("mid_rst_cnt", entry_cnt, 0);
        chk("mid_rst_code", bus.code_out, 0);
        chk("mid_rst_valid", bus.code_valid, 0);
        rst = 1'b0;
        key(4'h2, 1, 16'h0002, 0);
        repeat (128) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
